// File: rtl/tap_param.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, and
// BYPASS / IDCODE / boundary-scan / USER data registers with update latches.
module tap_param #(
  parameter int          IR_W   = 4,
  parameter int          BSR_W  = 8,
  parameter int          USER_W = 16,
  parameter logic [31:0] IDCODE = 32'h1000_0001
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_en,
  input  logic [BSR_W-1:0]  bs_pin_in,
  input  logic [BSR_W-1:0]  bs_core_in,
  output logic [BSR_W-1:0]  bs_out,
  output logic              bs_mode,
  input  logic [USER_W-1:0] user_din,
  output logic [USER_W-1:0] user_dout,
  output logic              user_upd,
  output logic [3:0]        tap_state,
  output logic [IR_W-1:0]   ir_out
);

  localparam logic [3:0] S_TLR   = 4'hF;
  localparam logic [3:0] S_RTI   = 4'hC;
  localparam logic [3:0] S_SELDR = 4'h7;
  localparam logic [3:0] S_CAPDR = 4'h6;
  localparam logic [3:0] S_SHDR  = 4'h2;
  localparam logic [3:0] S_EX1DR = 4'h1;
  localparam logic [3:0] S_PSDR  = 4'h3;
  localparam logic [3:0] S_EX2DR = 4'h0;
  localparam logic [3:0] S_UPDDR = 4'h5;
  localparam logic [3:0] S_SELIR = 4'h4;
  localparam logic [3:0] S_CAPIR = 4'hE;
  localparam logic [3:0] S_SHIR  = 4'hA;
  localparam logic [3:0] S_EX1IR = 4'h9;
  localparam logic [3:0] S_PSIR  = 4'hB;
  localparam logic [3:0] S_EX2IR = 4'h8;
  localparam logic [3:0] S_UPDIR = 4'hD;

  localparam logic [IR_W-1:0] OP_EXTEST = IR_W'(0);
  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(2);
  localparam logic [IR_W-1:0] OP_INTEST = IR_W'(3);
  localparam logic [IR_W-1:0] OP_USER   = IR_W'(4);

  logic [3:0]        state_q, state_d;
  logic [IR_W-1:0]   ir_sr_q, ir_sr_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              byp_q, byp_d;
  logic [31:0]       id_sr_q, id_sr_d;
  logic [BSR_W-1:0]  bsr_sr_q, bsr_sr_d;
  logic [USER_W-1:0] user_sr_q, user_sr_d;
  logic [BSR_W-1:0]  bs_out_q, bs_out_d;
  logic [USER_W-1:0] user_dout_q, user_dout_d;

  logic sel_bsr, sel_id, sel_user, sel_byp;

  // USER only exists when the opcode 4 fits in the instruction register
  always_comb begin
    sel_bsr  = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE) || (ir_q == OP_INTEST);
    sel_id   = (ir_q == OP_IDCODE);
    sel_user = (IR_W >= 3) && (ir_q == OP_USER);
    sel_byp  = !(sel_bsr || sel_id || sel_user);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TLR:   state_d = tms ? S_TLR   : S_RTI;
      S_RTI:   state_d = tms ? S_SELDR : S_RTI;
      S_SELDR: state_d = tms ? S_SELIR : S_CAPDR;
      S_CAPDR: state_d = tms ? S_EX1DR : S_SHDR;
      S_SHDR:  state_d = tms ? S_EX1DR : S_SHDR;
      S_EX1DR: state_d = tms ? S_UPDDR : S_PSDR;
      S_PSDR:  state_d = tms ? S_EX2DR : S_PSDR;
      S_EX2DR: state_d = tms ? S_UPDDR : S_SHDR;
      S_UPDDR: state_d = tms ? S_SELDR : S_RTI;
      S_SELIR: state_d = tms ? S_TLR   : S_CAPIR;
      S_CAPIR: state_d = tms ? S_EX1IR : S_SHIR;
      S_SHIR:  state_d = tms ? S_EX1IR : S_SHIR;
      S_EX1IR: state_d = tms ? S_UPDIR : S_PSIR;
      S_PSIR:  state_d = tms ? S_EX2IR : S_PSIR;
      S_EX2IR: state_d = tms ? S_UPDIR : S_SHIR;
      S_UPDIR: state_d = tms ? S_SELDR : S_RTI;
      default: state_d = S_TLR;
    endcase
  end

  always_comb begin
    ir_sr_d     = ir_sr_q;
    ir_d        = ir_q;
    byp_d       = byp_q;
    id_sr_d     = id_sr_q;
    bsr_sr_d    = bsr_sr_q;
    user_sr_d   = user_sr_q;
    bs_out_d    = bs_out_q;
    user_dout_d = user_dout_q;

    if (state_q == S_CAPIR) ir_sr_d = IR_W'(1);
    if (state_q == S_SHIR)  ir_sr_d = IR_W'({tdi, ir_sr_q} >> 1);

    // Forcing on entry keeps bs_mode low for every cycle spent in TLR
    if (state_d == S_TLR)        ir_d = OP_IDCODE;
    else if (state_q == S_UPDIR) ir_d = ir_sr_q;

    if (state_q == S_CAPDR) begin
      if (sel_byp)  byp_d     = 1'b0;
      if (sel_id)   id_sr_d   = IDCODE;
      if (sel_bsr)  bsr_sr_d  = (ir_q == OP_INTEST) ? bs_core_in : bs_pin_in;
      if (sel_user) user_sr_d = user_din;
    end

    if (state_q == S_SHDR) begin
      if (sel_byp)  byp_d     = tdi;
      if (sel_id)   id_sr_d   = 32'({tdi, id_sr_q} >> 1);
      if (sel_bsr)  bsr_sr_d  = BSR_W'({tdi, bsr_sr_q} >> 1);
      if (sel_user) user_sr_d = USER_W'({tdi, user_sr_q} >> 1);
    end

    if (state_q == S_UPDDR) begin
      if (sel_bsr)  bs_out_d    = bsr_sr_q;
      if (sel_user) user_dout_d = user_sr_q;
    end
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_TLR;
      ir_sr_q     <= '0;
      ir_q        <= OP_IDCODE;
      byp_q       <= 1'b0;
      id_sr_q     <= '0;
      bsr_sr_q    <= '0;
      user_sr_q   <= '0;
      bs_out_q    <= '0;
      user_dout_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_sr_q     <= ir_sr_d;
      ir_q        <= ir_d;
      byp_q       <= byp_d;
      id_sr_q     <= id_sr_d;
      bsr_sr_q    <= bsr_sr_d;
      user_sr_q   <= user_sr_d;
      bs_out_q    <= bs_out_d;
      user_dout_q <= user_dout_d;
    end
  end

  always_comb begin
    tdo_en = (state_q == S_SHIR) || (state_q == S_SHDR);
    tdo    = 1'b0;
    if (state_q == S_SHIR) tdo = ir_sr_q[0];
    else if (state_q == S_SHDR) begin
      if (sel_byp)       tdo = byp_q;
      else if (sel_id)   tdo = id_sr_q[0];
      else if (sel_bsr)  tdo = bsr_sr_q[0];
      else               tdo = user_sr_q[0];
    end
  end

  assign user_upd  = (state_q == S_UPDDR) && sel_user;
  assign bs_mode   = (ir_q == OP_EXTEST) || (ir_q == OP_INTEST);
  assign bs_out    = bs_out_q;
  assign user_dout = user_dout_q;
  assign tap_state = state_q;
  assign ir_out    = ir_q;

endmodule

// File: tb/tb_tap_param.sv
// Directed bench for tap_param: table of IR/DR transactions plus hand-written
// reset, test-logic-reset, pause and mid-shift reset sequences.
module tb_tap_param;

  logic        tck = 1'b0;
  logic        rst_n, tms, tdi;
  logic        tdo, tdo_en, bs_mode, user_upd;
  logic [7:0]  bs_pin_in, bs_core_in, bs_out;
  logic [15:0] user_din, user_dout;
  logic [3:0]  tap_state, ir_out;

  tap_param #(.IR_W(4), .BSR_W(8), .USER_W(16), .IDCODE(32'h1000_0001)) dut (
    .tck(tck), .rst_n(rst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .bs_pin_in(bs_pin_in), .bs_core_in(bs_core_in), .bs_out(bs_out), .bs_mode(bs_mode),
    .user_din(user_din), .user_dout(user_dout), .user_upd(user_upd),
    .tap_state(tap_state), .ir_out(ir_out)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic [3:0]  ir;
    int          n;
    logic [31:0] din;
    logic [7:0]  pin;
    logic [7:0]  core;
    logic [15:0] udin;
    logic [31:0] exp_tdo;
    logic [7:0]  exp_bs;
    logic [15:0] exp_ud;
    logic        exp_mode;
    int          exp_upd;
  } vec_t;

  vec_t tbl[8];
  int   nvec = 0, nerr = 0;
  int   en_seen = 0, upd_seen = 0;
  logic s_tdo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic m, input logic d);
    @(negedge tck);
    tms = m;
    tdi = d;
    #1;
    s_tdo = tdo;
    if (tdo_en)   en_seen++;
    if (user_upd) upd_seen++;
    @(posedge tck);
    #1;
  endtask

  // From RTI through the IR column and back to RTI
  task automatic load_ir(input logic [3:0] op, output logic [3:0] cap);
    cap = '0;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, op[i]);
      cap[i] = s_tdo;
    end
    step(1, 0); step(0, 0);
  endtask

  task automatic shift_dr(input logic [31:0] din, input int n, output logic [31:0] got);
    got = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      got[i] = s_tdo;
    end
    step(1, 0); step(0, 0);
  endtask

  initial begin
    logic [3:0]  cap;
    logic [31:0] got;
    int          e0, u0;

    tbl[0] = '{4'h1, 32, 32'h0,  8'h00, 8'h00, 16'h0000, 32'h1000_0001, 8'h00, 16'h0000, 1'b0, 0};
    tbl[1] = '{4'hF, 3,  32'h5,  8'h00, 8'h00, 16'h0000, 32'h2,         8'h00, 16'h0000, 1'b0, 0};
    tbl[2] = '{4'h2, 8,  32'h3C, 8'hA5, 8'h00, 16'h0000, 32'hA5,        8'h3C, 16'h0000, 1'b0, 0};
    tbl[3] = '{4'h4, 16, 32'h1234, 8'h00, 8'h00, 16'hBEEF, 32'hBEEF,    8'h3C, 16'h1234, 1'b0, 1};
    tbl[4] = '{4'h3, 8,  32'hC3, 8'h00, 8'h5A, 16'h0000, 32'h5A,        8'hC3, 16'h1234, 1'b1, 0};
    tbl[5] = '{4'h2, 8,  32'hFF, 8'h00, 8'h00, 16'h0000, 32'h00,        8'hFF, 16'h1234, 1'b0, 0};
    tbl[6] = '{4'h7, 4,  32'hB,  8'h00, 8'h00, 16'h0000, 32'h6,         8'hFF, 16'h1234, 1'b0, 0};
    tbl[7] = '{4'h0, 8,  32'h96, 8'h0F, 8'h00, 16'h0000, 32'h0F,        8'h96, 16'h1234, 1'b1, 0};

    rst_n = 1'b0; tms = 1'b1; tdi = 1'b0;
    bs_pin_in = '0; bs_core_in = '0; user_din = '0;
    repeat (3) @(posedge tck);
    #1;
    check("rst_state", tap_state, 4'hF);
    check("rst_ir", ir_out, 4'h1);
    check("rst_tdo", tdo, 0);
    check("rst_tdo_en", tdo_en, 0);
    check("rst_bs_out", bs_out, 0);
    check("rst_user_dout", user_dout, 0);
    check("rst_user_upd", user_upd, 0);
    check("rst_bs_mode", bs_mode, 0);

    @(negedge tck);
    tms = 1'b0;
    rst_n = 1'b1;
    @(posedge tck);
    #1;
    check("first_edge_rti", tap_state, 4'hC);

    for (int k = 0; k < 8; k++) begin
      bs_pin_in  = tbl[k].pin;
      bs_core_in = tbl[k].core;
      user_din   = tbl[k].udin;
      load_ir(tbl[k].ir, cap);
      check($sformatf("v%0d_ir_capture", k), cap, 4'b0001);
      check($sformatf("v%0d_ir_out", k), ir_out, tbl[k].ir);
      e0 = en_seen;
      u0 = upd_seen;
      shift_dr(tbl[k].din, tbl[k].n, got);
      check($sformatf("v%0d_tdo", k), got, tbl[k].exp_tdo);
      check($sformatf("v%0d_tdo_en_cycles", k), en_seen - e0, tbl[k].n);
      check($sformatf("v%0d_user_upd_cycles", k), upd_seen - u0, tbl[k].exp_upd);
      check($sformatf("v%0d_bs_out", k), bs_out, tbl[k].exp_bs);
      check($sformatf("v%0d_user_dout", k), user_dout, tbl[k].exp_ud);
      check($sformatf("v%0d_bs_mode", k), bs_mode, tbl[k].exp_mode);
      check($sformatf("v%0d_state_rti", k), tap_state, 4'hC);
    end

    // EXTEST is active; five tms=1 must reach TLR and drop bs_mode
    repeat (5) step(1, 0);
    check("tlr_state", tap_state, 4'hF);
    check("tlr_bs_mode", bs_mode, 0);
    check("tlr_ir", ir_out, 4'h1);
    check("tlr_bs_out_kept", bs_out, 8'h96);
    check("tlr_user_dout_kept", user_dout, 16'h1234);
    step(0, 0);

    // USER shift split by a pause: 8 ones, pause, 8 zeros
    user_din = 16'hA55A;
    load_ir(4'h4, cap);
    u0 = upd_seen;
    got = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 8; i++) begin
      step(i == 7, 1'b1);
      got[i] = s_tdo;
    end
    step(0, 0); step(0, 0);
    check("pause_state", tap_state, 4'h3);
    check("pause_tdo", s_tdo, 0);
    check("pause_tdo_en", tdo_en, 0);
    step(1, 0); step(0, 0);
    check("resume_state", tap_state, 4'h2);
    for (int i = 0; i < 8; i++) begin
      step(i == 7, 1'b0);
      got[8 + i] = s_tdo;
    end
    step(1, 0); step(0, 0);
    check("pause_tdo_stream", got, 32'hA55A);
    check("pause_user_dout", user_dout, 16'h00FF);
    check("pause_user_upd_cycles", upd_seen - u0, 1);
    check("pause_bs_out_kept", bs_out, 8'h96);

    // Reset in the middle of a SAMPLE shift must abort with no update
    bs_pin_in = 8'hA5;
    load_ir(4'h2, cap);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(0, i[0]);
    check("midshift_state", tap_state, 4'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", tap_state, 4'hF);
    check("async_rst_bs_out", bs_out, 0);
    check("async_rst_user_dout", user_dout, 0);
    check("async_rst_ir", ir_out, 4'h1);
    check("async_rst_tdo_en", tdo_en, 0);
    repeat (2) @(posedge tck);
    @(negedge tck);
    tms = 1'b0;
    rst_n = 1'b1;
    @(posedge tck);
    #1;
    check("post_rst_rti", tap_state, 4'hC);
    check("post_rst_bs_out", bs_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/tap_param.md
TAP_PARAM -- requirements
Module: tap_param

Interface
REQ-001 Parameter IR_W, default 4, instruction register width, legal range 2..8.
REQ-002 Parameter BSR_W, default 8, boundary-scan register length, at least 1.
REQ-003 Parameter USER_W, default 16, user data register length, at least 1.
REQ-004 Parameter IDCODE, default 32'h1000_0001, device ID; bit 0 SHALL be 1.
REQ-005 Clock and reset: one clock, tck; reset is asynchronous and active-low, rst_n.
REQ-006 tck  in  1  JTAG clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  async active-low reset.
REQ-008 tms  in  1  test mode select, sampled on rising edge of tck.
REQ-009 tdi  in  1  serial data in, sampled on rising edge of tck.
REQ-010 tdo  out  1  serial data out.
REQ-011 tdo_en  out  1  high in Shift-IR and Shift-DR only.
REQ-012 bs_pin_in  in  BSR_W  pin-side values captured by SAMPLE/EXTEST.
REQ-013 bs_core_in  in  BSR_W  core-side values captured by INTEST.
REQ-014 bs_out  out  BSR_W  boundary update register.
REQ-015 bs_mode  out  1  high while IR holds EXTEST or INTEST.
REQ-016 user_din  in  USER_W  value captured into the USER register.
REQ-017 user_dout  out  USER_W  USER update register.
REQ-018 user_upd  out  1  one-cycle pulse on USER Update-DR.
REQ-019 tap_state  out  4  current FSM state, IEEE 1149.1 encoding.
REQ-020 ir_out  out  IR_W  current instruction.

Function
REQ-021 The FSM SHALL implement the 16 IEEE 1149.1 TAP states and transitions, encoded TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
REQ-022 Five consecutive tms=1 cycles SHALL reach TLR from any state.
REQ-023 Opcodes: EXTEST=0, IDCODE=1, SAMPLE/PRELOAD=2, INTEST=3, USER=4, BYPASS=all ones; any other opcode SHALL select the BYPASS register.
REQ-024 In CapIR, the IR shift register SHALL load {zeros, 2'b01}.
REQ-025 In ShIR, the IR shift register SHALL shift right by 1, with tdi entering at MSB.
REQ-026 In UpdIR, ir_out SHALL load the IR shift register, visible the cycle after UpdIR.
REQ-027 In TLR, ir_out SHALL be forced to IDCODE.
REQ-028 CapDR loads the selected DR: BYPASS gets 0; IDCODE gets IDCODE; SAMPLE and EXTEST get bs_pin_in; INTEST gets bs_core_in; USER gets user_din.
REQ-029 In ShDR, the selected DR SHALL shift right by 1, with tdi entering at MSB and the other DRs held.
REQ-030 tdo SHALL equal bit 0 of the selected shift register (IR in IR branch, DR in DR branch) while tdo_en=1, and 0 otherwise.
REQ-031 UpdDR with SAMPLE, EXTEST or INTEST SHALL load bs_out from the BSR shift register.
REQ-032 UpdDR with USER SHALL load user_dout and assert user_upd for exactly the one UpdDR cycle.
REQ-033 UpdDR with IDCODE or BYPASS SHALL change no output.
REQ-034 Pause states and Exit states SHALL hold all shift registers unchanged.
REQ-035 bs_mode SHALL derive from ir_out only, and SHALL be 0 in TLR.
REQ-036 bs_out and user_dout SHALL be retained through TLR entered via tms.
REQ-037 Shift length SHALL be exact: IR_W, 1 (BYPASS), 32 (IDCODE), BSR_W, or USER_W bits between Capture and Update.

Reset
REQ-038 On rst_n=0 the block SHALL asynchronously reset to: tap_state=F, ir_out=IDCODE, all shift registers 0, bs_out=0, user_dout=0, user_upd=0, tdo=0, tdo_en=0, bs_mode=0.
REQ-039 Asserting rst_n mid-shift SHALL abort the shift with no Update effect.
REQ-040 After rst_n deasserts, the first rising edge of tck SHALL act on tms.

Verification
REQ-041 Reset, tms 0,1,0,0, then 32 ShDR cycles -> tdo streams 32'h1000_0001 LSB-first and the first bit is 1.
REQ-042 Load IR=4'hF, shift DR with tdi pattern 1,0,1 -> tdo shows 0,1,0 (1-cycle bypass delay).
REQ-043 Load IR=2 with bs_pin_in=8'hA5, shift 8 bits of tdi=8'h3C -> tdo gives 8'hA5 LSB-first; after UpdDR bs_out=8'h3C and bs_mode=0.
REQ-044 Load IR=0 -> bs_mode=1 after UpdIR; then issue 5x tms=1 -> tap_state=F, bs_mode=0, bs_out unchanged.
REQ-045 Load IR=4 with user_din=16'hBEEF, shift in 16'h1234 -> tdo gives 16'hBEEF; user_dout=16'h1234; user_upd high for exactly 1 cycle.
REQ-046 Assert rst_n=0 during ShDR of the REQ-043 sequence -> bs_out=0 and tap_state=F immediately, with no update.
